// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect request, instruction-memory read port and
// the decode-side valid/ready instruction stream.
//   master : the fetch unit (drives imem read, inst stream; receives redirect,
//            imem_q and inst_ready)
//   slave  : the environment (core control, instruction memory, decode)
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_read_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_q;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_read_en,
    output imem_addr,
    input  imem_q,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_read_en,
    input  imem_addr,
    output imem_q,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// Issues sequential word reads to a 2-cycle-latency instruction memory, tags
// each read with its PC and the current epoch, buffers returned words in a
// small FIFO and presents them to decode over valid/ready. A redirect flips
// the epoch, kills the in-flight reads and empties the buffer.
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_unit_if.master (redirect_*, imem_*, inst_*)
// Parameters:
//   RESET_PC    first PC fetched after reset
//   FIFO_DEPTH  instruction buffer entries, power of two, 4..16
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  // count + up to two live pipeline stages
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  // Fetch PC and epoch
  logic [XLEN-1:0]  pc_q;
  logic             epoch_q;

  // Two-stage in-flight read pipeline mirroring the memory latency
  logic             s0_valid_q;
  logic [XLEN-1:0]  s0_pc_q;
  logic             s0_epoch_q;
  logic             s1_valid_q;
  logic [XLEN-1:0]  s1_pc_q;
  logic             s1_epoch_q;

  // Instruction buffer
  entry_t           fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             redirect_c;
  logic [XLEN-1:0]  redirect_target_c;
  logic             s0_live_c;
  logic             s1_live_c;
  logic [OCC_W-1:0] occupancy_c;
  logic             issue_c;
  logic             arrive_c;
  logic             push_c;
  logic             pop_c;

  // Issue / arrival / handshake decode
  always_comb begin
    redirect_c        = bus.redirect_valid;
    redirect_target_c = bus.redirect_pc & 32'hFFFF_FFFC;
    s0_live_c         = s0_valid_q && (s0_epoch_q == epoch_q);
    s1_live_c         = s1_valid_q && (s1_epoch_q == epoch_q);
    // Reserve a buffer slot for every live read; a same-cycle pop earns no credit
    occupancy_c       = OCC_W'(count_q) + OCC_W'(s0_live_c) + OCC_W'(s1_live_c);
    issue_c           = rst_n && !redirect_c && (occupancy_c < OCC_W'(FIFO_DEPTH));
    arrive_c          = s1_live_c;
    // Redirect wins over a same-cycle arrival
    push_c            = arrive_c && !redirect_c;
    // A pop in a redirect cycle still completes
    pop_c             = (count_q != '0) && bus.inst_ready;
  end

  // Memory request and decode-side outputs
  always_comb begin
    bus.imem_read_en = issue_c;
    bus.imem_addr    = pc_q;
    bus.inst_valid   = (count_q != '0);
    bus.inst_data    = fifo_q[rd_ptr_q].data;
    bus.inst_pc      = fifo_q[rd_ptr_q].pc;
  end

  // PC, epoch and in-flight pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      epoch_q    <= 1'b0;
      s0_valid_q <= 1'b0;
      s0_pc_q    <= '0;
      s0_epoch_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_pc_q    <= '0;
      s1_epoch_q <= 1'b0;
    end else if (redirect_c) begin
      pc_q       <= redirect_target_c;
      epoch_q    <= ~epoch_q;
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      if (issue_c) begin
        pc_q <= pc_q + 32'd4;
      end
      s0_valid_q <= issue_c;
      s0_pc_q    <= pc_q;
      s0_epoch_q <= epoch_q;
      s1_valid_q <= s0_valid_q;
      s1_pc_q    <= s0_pc_q;
      s1_epoch_q <= s0_epoch_q;
    end
  end

  // Instruction buffer: head at rd_ptr, redirect empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_c) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q].pc   <= s1_pc_q;
        fifo_q[wr_ptr_q].data <= bus.imem_q;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Slot reservation at issue makes an arrival into a full buffer impossible
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(arrive_c && (count_q == CNT_W'(FIFO_DEPTH)))
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the processor core. Generates sequential PCs and issues word reads to the 2-cycle-latency instruction memory (`read_en`/`addr`/`q`). Buffers the returned words with their PCs in a small FIFO and hands them to decode over a valid/ready interface. Handles redirects (branch/jump/exception) by squashing in-flight reads and flushing the buffer.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, 4..16.

- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `redirect_valid`  in  1  redirect request; one-cycle pulse, may be held
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (forced 0)
- `imem_read_en`  out  1  memory read request this cycle
- `imem_addr`  out  32  byte address of the read (word aligned)
- `imem_q`  in  32  memory read data, valid 2 cycles after request
- `inst_valid`  out  1  `inst_data`/`inst_pc` hold a fetched instruction
- `inst_ready`  in  1  decode accepts the instruction this cycle
- `inst_data`  out  32  instruction word
- `inst_pc`  out  32  PC of `inst_data`

## Operation
- State: `pc` register; 2-stage in-flight pipeline (`valid`, `pc`, `epoch` per stage); 1-bit `epoch`; FIFO of {pc, data} with `count`.
- Issue condition: `rst_n` high, `redirect_valid` low, and `count + inflight < FIFO_DEPTH`. `inflight` counts live (non-squashed) pipeline stages. No credit is taken for a same-cycle pop.
- On issue: `imem_read_en`=1, `imem_addr`=`pc`, stage0 <= {1, pc, epoch}, `pc` <= `pc`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- When not issuing: `imem_read_en`=0, `imem_addr`=`pc` (don't-care to memory).
- Stage0 shifts to stage1 every cycle. Stage1 arriving in cycle N+2 pairs with `imem_q` that cycle. It is written into the FIFO iff stage1.valid and stage1.epoch == current epoch.
- Redirect (`redirect_valid`=1): `pc` <= {redirect_pc[31:2], 2'b00}; `epoch` toggles; FIFO `count` <= 0; both pipeline stages marked invalid. No issue and no FIFO write that cycle. Redirect wins over any same-cycle arrival.
- Output: `inst_valid` = (`count` != 0); `inst_data`/`inst_pc` = FIFO head. Pop on `inst_valid && inst_ready`. A handshake in a redirect cycle still completes; the consumer owns that instruction.
- FIFO never overflows by construction. An arrival with FIFO full is an assertion failure in simulation.
- Simultaneous push and pop: `count` unchanged and order preserved.
- Held `redirect_valid`: the unit re-targets every cycle and issues nothing until it drops.

## Timing
- Reset (async assert): `pc`=RESET_PC, `count`=0, pipeline invalid, `epoch`=0. `imem_read_en`=0 while `rst_n` low. `inst_valid`=0, `inst_data`=0, `inst_pc`=0 (cleared FIFO head).
- First issue occurs in the first cycle with `rst_n` high (cycle 0). Data is written at the end of cycle 2, and `inst_valid` rises in cycle 3.
- Redirect in cycle R: target issued in R+1, `inst_valid` for the target in R+4.
- Steady state, `inst_ready` held 1: one issue and one instruction per cycle, with `count` ≤ 1.
- Backpressure: issue stops once `count + inflight` = FIFO_DEPTH. After the stall, issue resumes the cycle after the first pop.
- Reset asserted mid-stream: all state clears immediately. Memory data arriving after release is discarded because the pipeline is invalid.

## Test plan
- Reset release with RESET_PC=0 and `inst_ready`=1 -> first issue at addr 0x0 in cycle 0. `inst_valid` in cycle 3 with `inst_pc`=0x0. The PCs that follow are 0x4, 0x8, … one per cycle, and `inst_data` matches the memory image.
- Hold `inst_ready`=0 for 10 cycles mid-stream -> at most FIFO_DEPTH outstanding words. `imem_read_en` stays 0 while saturated. On release, instructions resume in exact PC order with no gaps or duplicates.
- Redirect to 0x40 while 2 reads are in flight and the FIFO holds 2 -> nothing from the old stream appears after the redirect cycle. `inst_pc`=0x40 appears 4 cycles after the redirect.
- Redirect to 0x103 in the same cycle as a pop and an arrival -> pop completes, arrival is dropped, and the next `inst_pc` is 0x100.
- RESET_PC=32'hFFFF_FFF8 -> `inst_pc` sequence is 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Assert `rst_n` low asynchronously (between edges) mid-stream, hold 3 cycles, release -> `inst_valid` and `imem_read_en` drop immediately. The stream restarts from RESET_PC with no stale instruction delivered.
